// File: rtl/aes_pkg.sv
// Shared constants, state encoding and helpers for the SPI AES-key receiver.
package aes_pkg;

  localparam logic [8:0] KSIZE_128 = 9'd128;
  localparam logic [8:0] KSIZE_192 = 9'd192;
  localparam logic [8:0] KSIZE_256 = 9'd256;

  localparam logic [1:0] CODE_128  = 2'd0;
  localparam logic [1:0] CODE_192  = 2'd1;
  localparam logic [1:0] CODE_256  = 2'd2;
  localparam logic [1:0] CODE_NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // A zero key size marks an unsupported nk.
  function automatic logic [8:0] nkToKsize(input logic [7:0] nkVal);
    case (nkVal)
      8'd4:    return KSIZE_128;
      8'd6:    return KSIZE_192;
      8'd8:    return KSIZE_256;
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [1:0] ksizeToCode(input logic [8:0] ksize);
    case (ksize)
      KSIZE_128: return CODE_128;
      KSIZE_192: return CODE_192;
      KSIZE_256: return CODE_256;
      default:   return CODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI pin with one-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;
  logic [STAGES:0]   warm_q;

  // Pulses stay masked until the chain has refilled after reset, so a pin that is
  // already at its active level when reset drops is not mistaken for an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
      warm_q  <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], din_i};
      prev_q  <= chain_q[STAGES-1];
      warm_q  <= {warm_q[STAGES-1:0], 1'b1};
    end
  end

  assign rise_o = warm_q[STAGES] &  chain_q[STAGES-1] & ~prev_q;
  assign fall_o = warm_q[STAGES] & ~chain_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_key_receiver.sv
// SPI slave that collects a 128/192/256-bit AES key into a shadow register and
// publishes it atomically, returning a status byte on MISO during each frame.
module spi_key_receiver
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter bit CPOL         = 1'b0,
  parameter bit CPHA         = 1'b0,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              nk,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  output logic [MAX_KEY_BITS-1:0] key,
  output logic [8:0]              key_bits,
  output logic                    key_valid,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int IDXW = $clog2(MAX_KEY_BITS);

  logic sckRise, sckFall, csRise, csFall;
  logic sampleEdge, shiftEdge;
  logic [SYNC_STAGES-1:0] mosiChain_q;
  logic mosiSync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) uSckSync (
    .clk(clk), .reset(reset), .din_i(sck), .rise_o(sckRise), .fall_o(sckFall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uCsSync (
    .clk(clk), .reset(reset), .din_i(cs_n), .rise_o(csRise), .fall_o(csFall)
  );

  // MOSI only needs the same delay as SCK so the sampled bit lines up with the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosiChain_q <= '0;
    else       mosiChain_q <= {mosiChain_q[SYNC_STAGES-2:0], mosi};
  end

  assign mosiSync   = mosiChain_q[SYNC_STAGES-1];
  assign sampleEdge = (CPOL == CPHA) ? sckRise : sckFall;
  assign shiftEdge  = (CPOL == CPHA) ? sckFall : sckRise;

  state_t                  state_q, state_d;
  logic [MAX_KEY_BITS-1:0] shadow_q, shadow_d;
  logic [MAX_KEY_BITS-1:0] key_q, key_d;
  logic [8:0]              cnt_q, cnt_d;
  logic [8:0]              ksize_q, ksize_d;
  logic [8:0]              keyBits_q, keyBits_d;
  logic                    badNk_q, badNk_d;
  logic                    overflow_q, overflow_d;
  logic [7:0]              statusSh_q, statusSh_d;
  logic                    miso_q, miso_d;
  logic                    busy_q, busy_d;
  logic                    keyValid_q, keyValid_d;
  logic                    frameErr_q, frameErr_d;
  logic                    lastErr_q, lastErr_d;
  logic                    keyLoaded_q, keyLoaded_d;
  logic [1:0]              lastCode_q, lastCode_d;
  logic [7:0]              status;
  logic [8:0]              idxFull;
  logic [IDXW-1:0]         idx;
  logic                    ok;

  assign status = {lastErr_q, keyLoaded_q, 4'b0000, lastCode_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      key_q       <= '0;
      cnt_q       <= '0;
      ksize_q     <= '0;
      keyBits_q   <= '0;
      badNk_q     <= 1'b0;
      overflow_q  <= 1'b0;
      statusSh_q  <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      keyValid_q  <= 1'b0;
      frameErr_q  <= 1'b0;
      lastErr_q   <= 1'b0;
      keyLoaded_q <= 1'b0;
      lastCode_q  <= CODE_NONE;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      key_q       <= key_d;
      cnt_q       <= cnt_d;
      ksize_q     <= ksize_d;
      keyBits_q   <= keyBits_d;
      badNk_q     <= badNk_d;
      overflow_q  <= overflow_d;
      statusSh_q  <= statusSh_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      keyValid_q  <= keyValid_d;
      frameErr_q  <= frameErr_d;
      lastErr_q   <= lastErr_d;
      keyLoaded_q <= keyLoaded_d;
      lastCode_q  <= lastCode_d;
    end
  end

  // A sample edge and CS release in the same cycle store the bit before CHECK.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    key_d       = key_q;
    cnt_d       = cnt_q;
    ksize_d     = ksize_q;
    keyBits_d   = keyBits_q;
    badNk_d     = badNk_q;
    overflow_d  = overflow_q;
    statusSh_d  = statusSh_q;
    miso_d      = miso_q;
    busy_d      = busy_q;
    keyValid_d  = 1'b0;
    frameErr_d  = 1'b0;
    lastErr_d   = lastErr_q;
    keyLoaded_d = keyLoaded_q;
    lastCode_d  = lastCode_q;
    idxFull     = '0;
    idx         = '0;
    ok          = 1'b0;

    case (state_q)
      IDLE: begin
        if (csFall) begin
          state_d    = RECV;
          ksize_d    = nkToKsize(nk);
          badNk_d    = (nkToKsize(nk) == 9'd0);
          shadow_d   = '0;
          cnt_d      = '0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          statusSh_d = CPHA ? status : {status[6:0], 1'b0};
          miso_d     = CPHA ? 1'b0 : status[7];
        end
      end

      RECV: begin
        if (shiftEdge) begin
          miso_d     = statusSh_q[7];
          statusSh_d = {statusSh_q[6:0], 1'b0};
        end
        if (sampleEdge) begin
          if (cnt_q < ksize_q) begin
            idxFull          = MSB_FIRST ? (ksize_q - 9'd1 - cnt_q) : cnt_q;
            idx              = IDXW'(idxFull);
            shadow_d[idx]    = mosiSync;
            cnt_d            = cnt_q + 9'd1;
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (csRise) state_d = CHECK;
      end

      CHECK: begin
        ok = (cnt_q == ksize_q) && !overflow_q && !badNk_q;
        if (ok) begin
          key_d       = shadow_q;
          keyBits_d   = ksize_q;
          keyValid_d  = 1'b1;
          keyLoaded_d = 1'b1;
          lastErr_d   = 1'b0;
          lastCode_d  = ksizeToCode(ksize_q);
        end else begin
          frameErr_d = 1'b1;
          lastErr_d  = 1'b1;
        end
        busy_d     = 1'b0;
        miso_d     = 1'b0;
        statusSh_d = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign miso      = miso_q;
  assign miso_oe   = busy_q;
  assign busy      = busy_q;
  assign key       = key_q;
  assign key_bits  = keyBits_q;
  assign key_valid = keyValid_q;
  assign frame_err = frameErr_q;

endmodule

// File: tb/tb_spi_key_receiver.sv
// Scoreboard bench for spi_key_receiver across SPI modes 0, 3, CPOL=1/CPHA=0 and LSB-first.
module tb_spi_key_receiver;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] nk = 8'd4;
  logic       mosi = 1'b0;
  logic       sckI [4];
  logic       csI [4];
  logic [255:0] keyO [4];
  logic [8:0]   keyBitsO [4];
  logic         keyValidO [4];
  logic         frameErrO [4];
  logic         busyO [4];
  logic         misoO [4];
  logic         misoOeO [4];

  always #5 clk = ~clk;

  function automatic bit cpolOf(input int g);
    return (g == 1) || (g == 2);
  endfunction

  function automatic bit cphaOf(input int g);
    return (g == 1);
  endfunction

  // Instance 0: mode 0, 1: mode 3, 2: CPOL=1/CPHA=0, 3: mode 0 LSB-first.
  for (genvar g = 0; g < 4; g++) begin : gDut
    spi_key_receiver #(
      .MAX_KEY_BITS(256),
      .CPOL(cpolOf(g)),
      .CPHA(cphaOf(g)),
      .MSB_FIRST(g != 3),
      .SYNC_STAGES(2)
    ) uDut (
      .clk(clk), .reset(reset), .nk(nk), .sck(sckI[g]), .cs_n(csI[g]), .mosi(mosi),
      .miso(misoO[g]), .miso_oe(misoOeO[g]), .key(keyO[g]), .key_bits(keyBitsO[g]),
      .key_valid(keyValidO[g]), .frame_err(frameErrO[g]), .busy(busyO[g])
    );
  end

  typedef struct {
    int           inst;
    bit           isErr;
    logic [255:0] key;
    logic [8:0]   bits;
  } exp_t;

  exp_t         expQ [$];
  int           errors = 0;
  int           checks = 0;
  logic [255:0] modelKey [4];
  logic [8:0]   modelBits [4];

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushValid(input int inst, input logic [255:0] k, input logic [8:0] bits);
    exp_t e;
    e.inst = inst; e.isErr = 1'b0; e.key = k; e.bits = bits;
    expQ.push_back(e);
    modelKey[inst]  = k;
    modelBits[inst] = bits;
  endtask

  task automatic pushErr(input int inst);
    exp_t e;
    e.inst = inst; e.isErr = 1'b1; e.key = modelKey[inst]; e.bits = modelBits[inst];
    expQ.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      waitClk(1);
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain timeout: %0d events pending, expected 0", expQ.size());
      expQ.delete();
    end
    waitClk(4);
  endtask

  // Plays one SPI frame as master; fr[nBits-1] goes out first. A non-negative
  // resetAt pulses reset at that bit and abandons the frame.
  task automatic applyStimulus(input int inst, input logic [7:0] nkVal, input logic [511:0] fr,
                               input int nBits, input int resetAt, output logic [7:0] status);
    bit cpol, cpha, aborted;
    cpol    = cpolOf(inst);
    cpha    = cphaOf(inst);
    aborted = 1'b0;
    status  = 8'h00;
    nk      = nkVal;
    csI[inst] = 1'b0;
    waitClk(HALF);
    for (int i = 0; i < nBits && !aborted; i++) begin
      if (i == resetAt) begin
        reset = 1'b1;
        waitClk(2);
        reset = 1'b0;
        aborted = 1'b1;
      end else begin
        if (!cpha) begin
          mosi = fr[nBits-1-i];
          waitClk(HALF);
          if (i < 8) status = {status[6:0], misoO[inst]};
          sckI[inst] = ~cpol;
          waitClk(HALF);
          sckI[inst] = cpol;
        end else begin
          sckI[inst] = ~cpol;
          mosi = fr[nBits-1-i];
          waitClk(HALF);
          if (i < 8) status = {status[6:0], misoO[inst]};
          sckI[inst] = cpol;
          waitClk(HALF);
        end
        if (i == 8) begin
          checkOutput("busy mid-frame", 256'(busyO[inst]), 256'(1));
          checkOutput("miso_oe mid-frame", 256'(misoOeO[inst]), 256'(1));
        end
      end
    end
    waitClk(HALF);
    csI[inst] = 1'b1;
    waitClk(HALF);
  endtask

  // Monitor: every key_valid/frame_err pulse is matched against the next expectation.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (keyValidO[g] || frameErrO[g]) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected event: inst %0d valid=%0b err=%0b, expected no event",
                   g, keyValidO[g], frameErrO[g]);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("event instance", 256'(g), 256'(e.inst));
          checkOutput("frame_err", 256'(frameErrO[g]), 256'(e.isErr));
          checkOutput("key_valid", 256'(keyValidO[g]), 256'(!e.isErr));
          checkOutput("key", keyO[g], e.key);
          checkOutput("key_bits", 256'(keyBitsO[g]), 256'(e.bits));
        end
      end
    end
  end

  function automatic logic [255:0] mkKey(input int nbytes);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < nbytes; i++) k[8*(nbytes-1-i) +: 8] = 8'(i);
    return k;
  endfunction

  initial begin
    logic [255:0] k128, k192, k256, kAlt;
    logic [511:0] fr;
    logic [7:0]   st;

    k128 = mkKey(16);
    k192 = mkKey(24);
    k256 = mkKey(32);
    kAlt = {128'h0, ~k128[127:0]};
    for (int g = 0; g < 4; g++) begin
      sckI[g] = cpolOf(g);
      csI[g]  = 1'b1;
      modelKey[g]  = '0;
      modelBits[g] = '0;
    end

    reset = 1'b1;
    waitClk(3);
    checkOutput("reset key", keyO[0], 256'(0));
    checkOutput("reset key_bits", 256'(keyBitsO[0]), 256'(0));
    checkOutput("reset key_valid", 256'(keyValidO[0]), 256'(0));
    checkOutput("reset frame_err", 256'(frameErrO[0]), 256'(0));
    checkOutput("reset busy", 256'(busyO[0]), 256'(0));
    checkOutput("reset miso", 256'(misoO[0]), 256'(0));
    checkOutput("reset miso_oe", 256'(misoOeO[0]), 256'(0));
    reset = 1'b0;
    waitClk(5);

    $display("[TB] mode 0, nk=4, 128-bit key");
    pushValid(0, k128, 9'd128);
    applyStimulus(0, 8'd4, 512'(k128), 128, -1, st);
    checkOutput("status fresh mode0", 256'(st), 256'(8'h03));
    drain();

    $display("[TB] mode 3, nk=6, 192-bit key");
    pushValid(1, k192, 9'd192);
    applyStimulus(1, 8'd6, 512'(k192), 192, -1, st);
    checkOutput("status fresh mode3", 256'(st), 256'(8'h03));
    drain();

    $display("[TB] CPOL=1 CPHA=0, nk=6, 192-bit key");
    pushValid(2, k192, 9'd192);
    applyStimulus(2, 8'd6, 512'(k192), 192, -1, st);
    checkOutput("status fresh cpol1cpha0", 256'(st), 256'(8'h03));
    drain();

    $display("[TB] nk=8 short frame of 200 bits");
    pushErr(0);
    applyStimulus(0, 8'd8, 512'(k256 >> 56), 200, -1, st);
    drain();

    $display("[TB] nk=4 overflow frame of 130 bits");
    pushErr(0);
    fr = '0;
    fr[129:0] = {k128[127:0], 2'b11};
    applyStimulus(0, 8'd4, fr, 130, -1, st);
    drain();

    $display("[TB] frame after overflow reports status");
    pushValid(0, kAlt, 9'd128);
    applyStimulus(0, 8'd4, 512'(kAlt), 128, -1, st);
    checkOutput("status after overflow", 256'(st), 256'(8'hC0));
    drain();

    $display("[TB] nk=5 rejected");
    pushErr(0);
    applyStimulus(0, 8'd5, 512'(k128), 128, -1, st);
    checkOutput("status after good key", 256'(st), 256'(8'h40));
    drain();

    $display("[TB] reset at bit 64 of 256-bit frame");
    applyStimulus(0, 8'd8, 512'(k256), 256, 64, st);
    for (int g = 0; g < 4; g++) begin
      modelKey[g]  = '0;
      modelBits[g] = '0;
    end
    checkOutput("post-reset key", keyO[0], 256'(0));
    checkOutput("post-reset key_bits", 256'(keyBitsO[0]), 256'(0));
    checkOutput("post-reset busy", 256'(busyO[0]), 256'(0));
    checkOutput("post-reset miso", 256'(misoO[0]), 256'(0));
    checkOutput("post-reset miso_oe", 256'(misoOeO[0]), 256'(0));
    drain();

    $display("[TB] full 256-bit frame after reset");
    pushValid(0, k256, 9'd256);
    applyStimulus(0, 8'd8, 512'(k256), 256, -1, st);
    checkOutput("status after reset", 256'(st), 256'(8'h03));
    drain();

    $display("[TB] LSB-first, nk=4, first bit 1");
    pushValid(3, 256'(1), 9'd128);
    fr = '0;
    fr[127] = 1'b1;
    applyStimulus(3, 8'd4, fr, 128, -1, st);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
